// File: rtl/fsm_match_sched_if.sv
// Bundle of scheduler request/data inputs and grant/status outputs.
// The master side drives req_i/data_i, and the slave side is the scheduler.
interface fsm_match_sched_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 4
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   req_i;
  logic [NCH-1:0]   data_i;
  logic [NCH-1:0]   gnt_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] match_cnt_o;
  logic [CH_W-1:0]  ch_o;
  logic             abort_o;

  modport master (
    output req_i, data_i,
    input  gnt_o, busy_o, done_o, match_cnt_o, ch_o, abort_o
  );

  modport slave (
    input  req_i, data_i,
    output gnt_o, busy_o, done_o, match_cnt_o, ch_o, abort_o
  );
endinterface

// File: rtl/fsm_match_sched.sv
// Round-robin frame scheduler that shares one non-overlapping "11" detector among NCH serial channels.
// Optional FSM_SCHED_ABORT_EN: a granted channel that drops req_i aborts its frame.
module fsm_match_sched #(
  parameter int NCH       = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  fsm_match_sched_if.slave  bus
);
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BIT_W = $clog2(FRAME_LEN);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic {D0, D1} det_t;

  state_t           state_q, state_d;
  det_t             det_q, det_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CH_W-1:0]  rr_q, rr_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [NCH-1:0]   gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CH_W-1:0]  ch_out_q, ch_out_d;
  logic             pick_valid;
  logic [CH_W-1:0]  pick_ch;
  logic [CH_W-1:0]  cand;
  logic [CH_W-1:0]  next_ch;
  logic             bit_in;

  // Scan downward so the last hit is the first requester at or after rr_q.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    cand       = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = CH_W'((int'(rr_q) + i) % NCH);
      if (bus.req_i[cand]) begin
        pick_valid = 1'b1;
        pick_ch    = cand;
      end
    end
  end

  assign next_ch = (int'(ch_q) == NCH - 1) ? '0 : ch_q + 1'b1;
  assign bit_in  = bus.data_i[ch_q];

`ifdef FSM_SCHED_ABORT_EN
  logic abort_q, abort_d;
`endif

  always_comb begin
    state_d   = state_q;
    det_d     = det_q;
    ch_d      = ch_q;
    rr_d      = rr_q;
    bit_cnt_d = bit_cnt_q;
    run_cnt_d = run_cnt_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    match_d   = match_q;
    ch_out_d  = ch_out_q;
`ifdef FSM_SCHED_ABORT_EN
    abort_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_valid) begin
          state_d   = RUN;
          ch_d      = pick_ch;
          gnt_d     = NCH'(1) << pick_ch;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          det_d     = D0;
          run_cnt_d = '0;
        end
      end
      RUN: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        // A second consecutive 1 closes a match and restarts the search.
        if (bit_in) begin
          if (det_q == D1) begin
            det_d = D0;
            if (run_cnt_q != CNT_MAX) run_cnt_d = run_cnt_q + 1'b1;
          end else begin
            det_d = D1;
          end
        end else begin
          det_d = D0;
        end
        if (bit_cnt_q == LAST_BIT) begin
          state_d  = DONE;
          gnt_d    = '0;
          done_d   = 1'b1;
          match_d  = run_cnt_d;
          ch_out_d = ch_q;
          rr_d     = next_ch;
        end
`ifdef FSM_SCHED_ABORT_EN
        if (!bus.req_i[ch_q]) begin
          state_d  = IDLE;
          gnt_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b0;
          abort_d  = 1'b1;
          match_d  = match_q;
          ch_out_d = ch_q;
          rr_d     = next_ch;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      det_q     <= D0;
      ch_q      <= '0;
      rr_q      <= '0;
      bit_cnt_q <= '0;
      run_cnt_q <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= '0;
      ch_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      det_q     <= det_d;
      ch_q      <= ch_d;
      rr_q      <= rr_d;
      bit_cnt_q <= bit_cnt_d;
      run_cnt_q <= run_cnt_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      match_q   <= match_d;
      ch_out_q  <= ch_out_d;
    end
  end

`ifdef FSM_SCHED_ABORT_EN
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) abort_q <= 1'b0;
    else          abort_q <= abort_d;
  end
  assign bus.abort_o = abort_q;
`else
  assign bus.abort_o = 1'b0;
`endif

  assign bus.gnt_o       = gnt_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.match_cnt_o = match_q;
  assign bus.ch_o        = ch_out_q;
endmodule

// File: tb/tb_fsm_match_sched.sv
// Directed and randomized checks of fsm_match_sched against a frame-level reference model.
// Honours FSM_SCHED_ABORT_EN for the dropped-request scenario.
module tb_fsm_match_sched;
  logic clk_i = 1'b0;
  logic reset_i;
  int checks = 0;
  int errors = 0;
  int rr_model = 0;
  int last_match = 0;

  always #5 clk_i = ~clk_i;

  fsm_match_sched_if #(.NCH(4), .CNT_W(4)) bus ();
  fsm_match_sched_if #(.NCH(4), .CNT_W(4)) bus_long ();

  fsm_match_sched #(.NCH(4), .FRAME_LEN(8), .CNT_W(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  fsm_match_sched #(.NCH(4), .FRAME_LEN(40), .CNT_W(4)) dut_long (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus_long)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] data);
    bus.req_i  = req;
    bus.data_i = data;
  endtask

  // First requester at or after the rotating pointer, or -1 if none.
  function automatic int modelPick(input logic [3:0] req, input int rr);
    for (int i = 0; i < 4; i++) begin
      int c = (rr + i) % 4;
      if (req[c[1:0]]) return c;
    end
    return -1;
  endfunction

  // Greedy left-to-right pairing of adjacent ones, saturated to the counter width.
  function automatic int modelMatches(input bit bits[$], input int cnt_w);
    int n = 0;
    int i = 0;
    int lim = (1 << cnt_w) - 1;
    while (i < bits.size() - 1) begin
      if (bits[i] && bits[i + 1]) begin
        n++;
        i += 2;
      end else begin
        i++;
      end
    end
    return (n > lim) ? lim : n;
  endfunction

  // Called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE cycle.
  task automatic runFrame(input string tag, input logic [3:0] req_mask, input logic [7:0] frame_bits);
    int ch;
    bit bq[$];
    logic [3:0] d;
    logic [3:0] r;
    ch = modelPick(req_mask, rr_model);
    applyStimulus(req_mask, 4'($urandom));
    checkOutput({tag, " idle gnt"}, 32'(bus.gnt_o), 32'd0);
    if (ch < 0) begin
      @(negedge clk_i);
      return;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      checkOutput({tag, " run gnt"}, 32'(bus.gnt_o), 32'(1 << ch));
      checkOutput({tag, " run busy"}, 32'(bus.busy_o), 32'd1);
      checkOutput({tag, " run done"}, 32'(bus.done_o), 32'd0);
      bq.push_back(frame_bits[k]);
      d = 4'($urandom);
      d[ch] = frame_bits[k];
      r = 4'($urandom);
      r[ch] = 1'b1;
      applyStimulus(r, d);
    end
    @(negedge clk_i);
    last_match = modelMatches(bq, 4);
    checkOutput({tag, " done"}, 32'(bus.done_o), 32'd1);
    checkOutput({tag, " match_cnt"}, 32'(bus.match_cnt_o), 32'(last_match));
    checkOutput({tag, " ch_o"}, 32'(bus.ch_o), 32'(ch));
    checkOutput({tag, " done gnt"}, 32'(bus.gnt_o), 32'd0);
    checkOutput({tag, " done busy"}, 32'(bus.busy_o), 32'd1);
    checkOutput({tag, " abort"}, 32'(bus.abort_o), 32'd0);
    rr_model = (ch + 1) % 4;
    applyStimulus(req_mask, 4'd0);
    @(negedge clk_i);
    checkOutput({tag, " after done"}, 32'(bus.done_o), 32'd0);
    checkOutput({tag, " after busy"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    bit bq[$];
    bit lq[$];
    int n;
    int order[5] = '{0, 1, 2, 3, 0};
    reset_i = 1'b0;
    applyStimulus(4'd0, 4'd0);
    bus_long.req_i  = 4'd0;
    bus_long.data_i = 4'd0;

    // Reset values.
    repeat (2) @(negedge clk_i);
    checkOutput("rst gnt", 32'(bus.gnt_o), 32'd0);
    checkOutput("rst busy", 32'(bus.busy_o), 32'd0);
    checkOutput("rst done", 32'(bus.done_o), 32'd0);
    checkOutput("rst match", 32'(bus.match_cnt_o), 32'd0);
    checkOutput("rst ch", 32'(bus.ch_o), 32'd0);
    checkOutput("rst abort", 32'(bus.abort_o), 32'd0);
    checkOutput("rst long gnt", 32'(bus_long.gnt_o), 32'd0);
    reset_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("idle no req gnt", 32'(bus.gnt_o), 32'd0);
      checkOutput("idle no req busy", 32'(bus.busy_o), 32'd0);
    end

    // Single requester on channel 2 with a known bit pattern.
    runFrame("ch2 frame", 4'b0100, 8'b0111_1011);
    checkOutput("ch2 match const", 32'(bus.match_cnt_o), 32'd3);
    checkOutput("ch2 ch const", 32'(bus.ch_o), 32'd2);

    for (int i = 0; i < 6; i++)
      runFrame("rand frame", 4'($urandom_range(1, 15)), 8'($urandom));

    // Asynchronous reset in the middle of a frame.
    applyStimulus(4'b1111, 4'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      applyStimulus(4'b1111, 4'($urandom));
    end
    reset_i = 1'b0;
    #1;
    checkOutput("midrst gnt", 32'(bus.gnt_o), 32'd0);
    checkOutput("midrst busy", 32'(bus.busy_o), 32'd0);
    checkOutput("midrst done", 32'(bus.done_o), 32'd0);
    checkOutput("midrst match", 32'(bus.match_cnt_o), 32'd0);
    applyStimulus(4'd0, 4'd0);
    @(negedge clk_i);
    reset_i = 1'b1;
    rr_model = 0;
    last_match = 0;
    @(negedge clk_i);
    checkOutput("post rst done", 32'(bus.done_o), 32'd0);

    // All channels requesting continuously.
    for (int i = 0; i < 5; i++) begin
      runFrame("rr frame", 4'b1111, 8'($urandom));
      checkOutput("rr order", 32'(bus.ch_o), 32'(order[i]));
    end

    // Channel 1 drops its request partway through its frame.
    applyStimulus(4'b0010, 4'd0);
    @(negedge clk_i);
    checkOutput("drop gnt", 32'(bus.gnt_o), 32'b0010);
    bq.delete();
    for (int k = 0; k < 4; k++) begin
      bq.push_back(1'b1);
      applyStimulus((k == 3) ? 4'b0100 : 4'b0010, 4'b0010);
      @(negedge clk_i);
    end
`ifdef FSM_SCHED_ABORT_EN
    checkOutput("abort pulse", 32'(bus.abort_o), 32'd1);
    checkOutput("abort gnt", 32'(bus.gnt_o), 32'd0);
    checkOutput("abort done", 32'(bus.done_o), 32'd0);
    checkOutput("abort ch", 32'(bus.ch_o), 32'd1);
    checkOutput("abort match kept", 32'(bus.match_cnt_o), 32'(last_match));
    rr_model = 2;
`else
    checkOutput("no abort pulse", 32'(bus.abort_o), 32'd0);
    checkOutput("no abort gnt", 32'(bus.gnt_o), 32'b0010);
    for (int k = 4; k < 8; k++) begin
      bq.push_back(k[0]);
      applyStimulus(4'b0100, {2'b00, k[0], 1'b0});
      @(negedge clk_i);
    end
    last_match = modelMatches(bq, 4);
    checkOutput("noabort done", 32'(bus.done_o), 32'd1);
    checkOutput("noabort ch", 32'(bus.ch_o), 32'd1);
    checkOutput("noabort match", 32'(bus.match_cnt_o), 32'(last_match));
    rr_model = 2;
    @(negedge clk_i);
`endif
    runFrame("after drop", 4'b0100, 8'($urandom));
    applyStimulus(4'd0, 4'd0);

    // Long frame of all ones saturates the count.
    lq.delete();
    for (int k = 0; k < 40; k++) lq.push_back(1'b1);
    bus_long.req_i  = 4'b0001;
    bus_long.data_i = 4'b1111;
    n = 0;
    while (n < 60 && bus_long.done_o !== 1'b1) begin
      @(negedge clk_i);
      n++;
    end
    bus_long.req_i = 4'd0;
    checkOutput("long done seen", 32'(bus_long.done_o), 32'd1);
    checkOutput("long latency", 32'(n), 32'd41);
    checkOutput("long match", 32'(bus_long.match_cnt_o), 32'(modelMatches(lq, 4)));
    checkOutput("long match sat", 32'(bus_long.match_cnt_o), 32'd15);
    checkOutput("long ch", 32'(bus_long.ch_o), 32'd0);
    @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
